frame_rx_scheduler: RTL and testbench

//  Shares one 8->32 frame assembler among N_LANES byte sources on the div_8_clk domain.

---
 rtl/frame_rx_scheduler_pkg.sv | 17 +
 rtl/frame_rx_scheduler_if.sv | 33 +++
 rtl/frame_rx_scheduler_rr_arbiter.sv | 29 ++
 rtl/frame_rx_scheduler.sv | 148 ++++++++++++++
 tb/tb_frame_rx_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_rx_scheduler_pkg.sv
// Shared types and constants for the frame receive scheduler.
// Holds the FSM state encoding, default frame constants and a width helper.
package frame_rx_pkg;

   typedef enum logic [1:0] {IDLE, HUNT, COLLECT, OUT} state_t;

   localparam logic [3:0]  DEF_HDR_NIB = 4'hA;
   localparam logic [15:0] DEF_TRAILER = 16'hBEAF;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/frame_rx_scheduler_if.sv
// Lane byte inputs, assembled-frame output and status flags of the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface frame_rx_scheduler_if
   import frame_rx_pkg::*;
#(
   parameter int N_LANES = 4,
   parameter int LW      = (clog2(N_LANES) < 1) ? 1 : clog2(N_LANES)
) ();

   // Transfer on a channel happens at a rising edge where valid and ready are both high;
   // frame_valid and its payload are held until frame_ready, req_ready depends only on state.
   logic [N_LANES-1:0]   req_valid;
   logic [8*N_LANES-1:0] req_data;
   logic [N_LANES-1:0]   req_ready;
   logic [31:0]          frame_data;
   logic [LW-1:0]        frame_lane;
   logic                 frame_valid;
   logic                 frame_ready;
   logic                 err_trailer;
   logic                 err_timeout;
   logic                 busy;

   modport slave (
      input  req_valid, req_data, frame_ready,
      output req_ready, frame_data, frame_lane, frame_valid, err_trailer, err_timeout, busy
   );

   modport master (
      output req_valid, req_data, frame_ready,
      input  req_ready, frame_data, frame_lane, frame_valid, err_trailer, err_timeout, busy
   );

endinterface

// File: rtl/frame_rx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane after ptr, wrapping.
module rr_arbiter
   import frame_rx_pkg::*;
#(
   parameter  int N  = 4,
   localparam int LW = (clog2(N) < 1) ? 1 : clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] ptr,
   output logic [LW-1:0] gnt_idx,
   output logic          any
);

   logic [LW-1:0] idx;

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int i = 1; i <= N; i++) begin
         idx = LW'((int'(ptr) + i) % N);
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/frame_rx_scheduler.sv
// Shares one 8->32 frame assembler among N_LANES byte sources, round-robin per frame.
// Hunts a header byte, collects four bytes MSB-first and forwards frames with a good trailer.
module frame_rx_scheduler
   import frame_rx_pkg::*;
#(
   parameter  int          N_LANES = 4,
   parameter  int          TIMEOUT = 15,
   parameter  logic [3:0]  HDR_NIB = DEF_HDR_NIB,
   parameter  logic [15:0] TRAILER = DEF_TRAILER,
   localparam int          LW      = (clog2(N_LANES) < 1) ? 1 : clog2(N_LANES),
   localparam int          TW      = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1)
) (
   input  logic                 div_8_clk,
   input  logic                 rst,
   frame_rx_scheduler_if.slave  bus,
   output state_t               dbg_state
);

   state_t        state, state_nxt;
   logic [LW-1:0] rr_ptr, grant, arb_gnt;
   logic          arb_any;
   logic [23:0]   shift_reg;
   logic [1:0]    cnt;
   logic [TW-1:0] tmo;
   logic [7:0]    lane_byte;
   logic          lane_valid, accept, hdr_hit, trailer_ok, tmo_hit;
   logic [31:0]   word;

   rr_arbiter #(.N(N_LANES)) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .gnt_idx (arb_gnt),
      .any     (arb_any)
   );

   always_comb begin
      lane_byte  = '0;
      lane_valid = 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
         if (grant == LW'(i)) begin
            lane_byte  = bus.req_data[8*i +: 8];
            lane_valid = bus.req_valid[i];
         end
      end
   end

   assign accept     = lane_valid && (state == HUNT || state == COLLECT);
   assign hdr_hit    = lane_byte[7:4] == HDR_NIB;
   assign word       = {shift_reg, lane_byte};
   assign trailer_ok = word[15:0] == TRAILER;
   assign tmo_hit    = tmo == TW'(TIMEOUT - 1);

   always_ff @(posedge div_8_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (arb_any) state_nxt = HUNT;
         HUNT: begin
            if (!lane_valid)  state_nxt = IDLE;
            else if (hdr_hit) state_nxt = COLLECT;
         end
         COLLECT: begin
            // A byte arriving on the last allowed cycle beats the timeout.
            if (accept) begin
               if (cnt == 2'd3) state_nxt = trailer_ok ? OUT : IDLE;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
            end
         end
         OUT:     if (bus.frame_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < N_LANES; i++) begin
         bus.req_ready[i] = (state == HUNT || state == COLLECT) && (grant == LW'(i));
      end
      bus.busy  = state != IDLE;
      dbg_state = state;
   end

   always_ff @(posedge div_8_clk) begin
      if (rst) begin
         rr_ptr          <= LW'(N_LANES - 1);
         grant           <= '0;
         shift_reg       <= '0;
         cnt             <= '0;
         tmo             <= '0;
         bus.frame_data  <= '0;
         bus.frame_lane  <= '0;
         bus.frame_valid <= 1'b0;
         bus.err_trailer <= 1'b0;
         bus.err_timeout <= 1'b0;
      end else begin
         bus.err_trailer <= 1'b0;
         bus.err_timeout <= 1'b0;
         unique case (state)
            IDLE: if (arb_any) grant <= arb_gnt;
            HUNT: begin
               if (!lane_valid) begin
                  rr_ptr <= grant;
               end else if (hdr_hit) begin
                  shift_reg <= {16'h0, lane_byte};
                  cnt       <= 2'd1;
                  tmo       <= '0;
               end
            end
            COLLECT: begin
               if (accept) begin
                  tmo <= '0;
                  if (cnt == 2'd3) begin
                     if (trailer_ok) begin
                        bus.frame_data  <= word;
                        bus.frame_lane  <= grant;
                        bus.frame_valid <= 1'b1;
                     end else begin
                        bus.err_trailer <= 1'b1;
                        rr_ptr          <= grant;
                     end
                  end else begin
                     shift_reg <= word[23:0];
                     cnt       <= cnt + 2'd1;
                  end
               end else if (tmo_hit) begin
                  bus.err_timeout <= 1'b1;
                  rr_ptr          <= grant;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            OUT: begin
               if (bus.frame_ready) begin
                  bus.frame_valid <= 1'b0;
                  rr_ptr          <= grant;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_rx_scheduler.sv
// Bench for frame_rx_scheduler: per-lane byte streams, a frame scoreboard keyed by lane
// and a reference model that derives frames and errors from the header/trailer rules.
module tb_frame_rx_scheduler;
   import frame_rx_pkg::*;

   localparam int NL = 4;
   localparam int LW = 2;

   logic   div_8_clk = 1'b0;
   logic   rst;
   state_t dbg_state;

   always #5 div_8_clk = ~div_8_clk;

   frame_rx_scheduler_if #(.N_LANES(NL), .LW(LW)) bif ();

   frame_rx_scheduler #(.N_LANES(NL), .TIMEOUT(15), .HDR_NIB(4'hA), .TRAILER(16'hBEAF)) dut (
      .div_8_clk (div_8_clk),
      .rst       (rst),
      .bus       (bif),
      .dbg_state (dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [33:0]   exp_q[$];
   logic [LW-1:0] lane_log[$];
   int exp_trl = 0, exp_tmo = 0, obs_trl = 0, obs_tmo = 0;

   logic [7:0]    lane_buf [NL][256];
   int            wr_p [NL];
   int            rd_p [NL];
   int            gap_run [NL];
   bit            gap_en = 0, fr_rand = 0;
   logic [NL-1:0] ready_s;
   logic          rst_s;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit lanes_busy();
      for (int i = 0; i < NL; i++) if (rd_p[i] < wr_p[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_lanes();
      for (int i = 0; i < NL; i++) begin
         wr_p[i] = 0; rd_p[i] = 0; gap_run[i] = 0;
      end
   endtask

   task automatic push_byte(int lane, logic [7:0] b);
      lane_buf[lane][8'(wr_p[lane])] = b;
      wr_p[lane]++;
   endtask

   // Reference model: a frame is good when it starts with the header nibble and ends in BEAF.
   task automatic send_frame(int lane, logic [31:0] w);
      for (int k = 3; k >= 0; k--) push_byte(lane, w[8*k +: 8]);
      if (w[31:28] == 4'hA) begin
         if (w[15:0] == 16'hBEAF) exp_q.push_back({2'(lane), w});
         else exp_trl++;
      end
   endtask

   task automatic step();
      for (int i = 0; i < NL; i++) begin
         if (rd_p[i] < wr_p[i] && !(gap_en && gap_run[i] < 3 && $urandom_range(0, 7) == 0)) begin
            gap_run[i] = 0;
            bif.req_valid[i] = 1'b1;
            bif.req_data[8*i +: 8] = lane_buf[i][8'(rd_p[i])];
         end else begin
            if (rd_p[i] < wr_p[i]) gap_run[i]++;
            bif.req_valid[i] = 1'b0;
         end
      end
      if (fr_rand) bif.frame_ready = ($urandom_range(0, 3) != 0);
      @(negedge div_8_clk);
      ready_s = bif.req_ready;
      rst_s   = rst;
      @(posedge div_8_clk);
      #1;
      for (int i = 0; i < NL; i++)
         if (!rst_s && bif.req_valid[i] && ready_s[i]) rd_p[i]++;
   endtask

   task automatic drain_lanes(int bound);
      int n = 0;
      while (lanes_busy() && n < bound) begin step(); n++; end
      check("lane_drain_bound", 64'(lanes_busy()), 0);
   endtask

   task automatic drain_frames(int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin step(); n++; end
      check("frame_drain_bound", 64'(exp_q.size()), 0);
   endtask

   task automatic check_reset_values(string tag);
      check({tag, "_frame_valid"}, 64'(bif.frame_valid), 0);
      check({tag, "_frame_data"},  64'(bif.frame_data), 0);
      check({tag, "_frame_lane"},  64'(bif.frame_lane), 0);
      check({tag, "_req_ready"},   64'(bif.req_ready), 0);
      check({tag, "_errs"},        64'({bif.err_trailer, bif.err_timeout}), 0);
      check({tag, "_busy"},        64'(bif.busy), 0);
      check({tag, "_state"},       64'(dbg_state), 64'(IDLE));
   endtask

   task automatic apply_reset(string tag);
      clear_lanes();
      rst = 1'b1;
      step();
      check_reset_values(tag);
      rst = 1'b0;
   endtask

   // Monitor: pops expected frames on each handshake and watches pulse and hold rules.
   logic        prev_pend = 1'b0, prev_trl = 1'b0, prev_tmo = 1'b0;
   logic [31:0] prev_data;
   logic [LW-1:0] prev_lane;
   always @(negedge div_8_clk) begin
      int found;
      if (rst) begin
         prev_pend = 1'b0; prev_trl = 1'b0; prev_tmo = 1'b0;
      end else begin
         if (prev_pend) begin
            check("frame_held", 64'(bif.frame_valid), 1);
            check("frame_stable", 64'({bif.frame_lane, bif.frame_data}), 64'({prev_lane, prev_data}));
         end
         if (bif.frame_valid) check("ready_low_in_out", 64'(bif.req_ready), 0);
         if (bif.err_trailer) begin
            obs_trl++;
            check("trl_pulse_width", 64'(prev_trl), 0);
         end
         if (bif.err_timeout) begin
            obs_tmo++;
            check("tmo_pulse_width", 64'(prev_tmo), 0);
         end
         if (bif.frame_valid && bif.frame_ready) begin
            lane_log.push_back(bif.frame_lane);
            found = -1;
            for (int k = 0; k < exp_q.size(); k++)
               if (found < 0 && exp_q[k][33:32] == bif.frame_lane) found = k;
            if (found < 0) begin
               check("unexpected_frame", 64'({bif.frame_lane, bif.frame_data}), 0);
            end else begin
               check("frame_data", 64'(bif.frame_data), 64'(exp_q[found][31:0]));
               exp_q.delete(found);
            end
         end
         prev_pend = bif.frame_valid && !bif.frame_ready;
         prev_data = bif.frame_data;
         prev_lane = bif.frame_lane;
         prev_trl  = bif.err_trailer;
         prev_tmo  = bif.err_timeout;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [7:0]  b;
      int          lane, pk;
      rst = 1'b1;
      bif.req_valid = '0;
      bif.req_data = '0;
      bif.frame_ready = 1'b1;
      clear_lanes();
      repeat (3) @(posedge div_8_clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;

      // Single lane frame, valid the cycle after byte 4.
      send_frame(0, 32'hA122BEAF);
      drain_lanes(50);
      check("t1_valid_latency", 64'(bif.frame_valid), 1);
      check("t1_frame_data", 64'(bif.frame_data), 64'h0A122BEAF);
      check("t1_frame_lane", 64'(bif.frame_lane), 0);
      drain_frames(50);

      // Three lanes competing: order 0,1,2,0.
      apply_reset("t2_reset");
      lane_log.delete();
      send_frame(0, 32'hA0010203 & 32'hFFFF0000 | 32'h0000BEAF);
      send_frame(0, 32'hA0FFBEAF);
      send_frame(1, 32'hA111BEAF);
      send_frame(2, 32'hA222BEAF);
      drain_lanes(200);
      drain_frames(200);
      check("t2_grants", 64'(lane_log.size()), 4);
      if (lane_log.size() == 4)
         check("t2_order", 64'({lane_log[0], lane_log[1], lane_log[2], lane_log[3]}), 64'({2'd0, 2'd1, 2'd2, 2'd0}));

      // Junk byte dropped, bad trailer gives one error pulse and no frame.
      push_byte(1, 8'h55);
      send_frame(1, 32'hA0112233);
      drain_lanes(50);
      check("t3_err_trailer", 64'(bif.err_trailer), 1);
      check("t3_busy_fell", 64'(bif.busy), 0);
      check("t3_no_frame", 64'(bif.frame_valid), 0);
      step();
      check("t3_pulse_end", 64'(bif.err_trailer), 0);

      // Stall of 15 idle cycles aborts; 14 is tolerated.
      push_byte(0, 8'hA5);
      push_byte(0, 8'h12);
      drain_lanes(50);
      exp_tmo++;
      repeat (14) step();
      check("t4_no_early_timeout", 64'(bif.err_timeout), 0);
      step();
      check("t4_err_timeout", 64'(bif.err_timeout), 1);
      check("t4_state_idle", 64'(dbg_state), 64'(IDLE));
      step();
      check("t4_pulse_end", 64'(bif.err_timeout), 0);
      push_byte(0, 8'hA5);
      push_byte(0, 8'h12);
      drain_lanes(50);
      repeat (14) step();
      check("t4b_still_busy", 64'(bif.busy), 1);
      push_byte(0, 8'hBE);
      push_byte(0, 8'hAF);
      exp_q.push_back({2'd0, 32'hA512BEAF});
      drain_lanes(50);
      check("t4b_frame", 64'(bif.frame_data), 64'hA512BEAF);
      drain_frames(50);

      // Backpressure on the frame port holds the frame and blocks all lanes.
      bif.frame_ready = 1'b0;
      send_frame(2, 32'hA2C3BEAF);
      send_frame(3, 32'hA344BEAF);
      while (!bif.frame_valid && lanes_busy()) step();
      for (int c = 0; c < 10; c++) begin
         step();
         check("t5_hold_valid", 64'(bif.frame_valid), 1);
         check("t5_hold_data", 64'({bif.frame_lane, bif.frame_data}), 64'({2'd2, 32'hA2C3BEAF}));
         check("t5_ready_zero", 64'(bif.req_ready), 0);
      end
      bif.frame_ready = 1'b1;
      step();
      check("t5_accepted", 64'(bif.frame_valid), 0);
      drain_lanes(50);
      drain_frames(50);

      // Reset inside COLLECT and inside OUT; lane 0 wins afterwards.
      push_byte(0, 8'hA1);
      push_byte(0, 8'h22);
      drain_lanes(50);
      check("t6_in_collect", 64'(dbg_state), 64'(COLLECT));
      apply_reset("t6_collect_reset");
      bif.frame_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w = 32'hA177BEAF;
         push_byte(1, w[8*(3-k) +: 8]);
      end
      drain_lanes(50);
      check("t6_pending", 64'(bif.frame_valid), 1);
      apply_reset("t6_out_reset");
      bif.frame_ready = 1'b1;
      lane_log.delete();
      send_frame(1, 32'hA1AABEAF);
      send_frame(0, 32'hA0BBBEAF);
      drain_lanes(100);
      drain_frames(100);
      check("t6_first_lane0", 64'(lane_log.size() > 0 ? lane_log[0] : 2'd3), 0);

      // Randomised traffic on all lanes with gaps and random backpressure.
      clear_lanes();
      gap_en = 1;
      fr_rand = 1;
      for (pk = 0; pk < 40; pk++) begin
         lane = $urandom_range(0, NL - 1);
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b[7:4] == 4'hA) b[7:4] = 4'h5;
            push_byte(lane, b);
         end
         w = {4'hA, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 16'hBEAF};
         if ($urandom_range(0, 3) == 0) begin
            w[15:0] = 16'($urandom_range(0, 65535));
            if (w[15:0] == 16'hBEAF) w[0] = 1'b0;
         end
         send_frame(lane, w);
      end
      drain_lanes(20000);
      fr_rand = 0;
      bif.frame_ready = 1'b1;
      drain_frames(200);
      repeat (3) step();

      check("end_exp_q_empty", 64'(exp_q.size()), 0);
      check("end_trailer_errs", 64'(obs_trl), 64'(exp_trl));
      check("end_timeout_errs", 64'(obs_tmo), 64'(exp_tmo));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
